keypad_scanner: RTL and testbench

Scans a 4x4 matrix keypad, synchronizes and debounces the row inputs, and encodes each accepted keypress as a 4-bit hex value (0-15) with a single-cycle strobe. It sits directly upstream of the color-entry stage, whose button_pressed/button inputs it drives. That stage assembles six successive nibbles into a 24-bit color. Exactly one strobe is issued per physical press, and the key must be released before another press is accepted.

---
 rtl/keypad_scanner.sv | 141 ++++++++++++++
 tb/tb_keypad_scanner.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row synchronizer, debounce and hex encode.
// One strobe per accepted press; the key must be released before the next press counts.
//
// state        | meaning
// -------------+------------------------------------------------------------
// SCAN         | drive one column per dwell period, sample rows on last cycle
// DEBOUNCE     | captured row must stay active DEBOUNCE_CYCLES in a row
// PRESS        | one-cycle strobe, button loaded with {row, col}
// WAIT_RELEASE | captured row must stay inactive DEBOUNCE_CYCLES in a row
module keypad_scanner #(
  parameter int SCAN_TICKS      = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic       button_pressed,
  output logic [3:0] button,
  output logic       key_held
);

  localparam int CNT_MAX = (SCAN_TICKS > DEBOUNCE_CYCLES) ? SCAN_TICKS : DEBOUNCE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_TICKS - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT   = CW'(CNT_MAX);

  typedef enum logic [1:0] {
    SCAN         = 2'd0,
    DEBOUNCE     = 2'd1,
    PRESS        = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    sync1, rows_s;
  logic [1:0]    col, col_nxt;
  logic [1:0]    cap_row, cap_row_nxt;
  logic [1:0]    low_row;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic [3:0]    button_nxt;
  logic          any_row, row_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 4'h0;
      rows_s <= 4'h0;
    end else begin
      sync1  <= ~row_n;
      rows_s <= sync1;
    end
  end

  // Lowest row index wins when several keys share the driven column.
  always_comb begin
    low_row = 2'd3;
    if (rows_s[0])      low_row = 2'd0;
    else if (rows_s[1]) low_row = 2'd1;
    else if (rows_s[2]) low_row = 2'd2;
  end

  assign any_row = |rows_s;
  assign row_hit = rows_s[cap_row];
  assign cnt_inc = (cnt < CNT_SAT) ? cnt + CW'(1) : cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= SCAN;
      col     <= 2'd0;
      cap_row <= 2'd0;
      cnt     <= '0;
      button  <= 4'h0;
    end else begin
      state   <= state_nxt;
      col     <= col_nxt;
      cap_row <= cap_row_nxt;
      cnt     <= cnt_nxt;
      button  <= button_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    col_nxt     = col;
    cap_row_nxt = cap_row;
    cnt_nxt     = cnt;
    button_nxt  = button;
    case (state)
      SCAN: begin
        if (cnt >= SCAN_LAST) begin
          if (any_row) begin
            cap_row_nxt = low_row;
            cnt_nxt     = CW'(1);
            state_nxt   = DEBOUNCE;
          end else begin
            col_nxt = col + 2'd1;
            cnt_nxt = '0;
          end
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      DEBOUNCE: begin
        if (!row_hit) begin
          state_nxt = SCAN;
          col_nxt   = col + 2'd1;
          cnt_nxt   = '0;
        end else if (cnt >= DEB_LAST) begin
          // Load the code now so it is valid in the strobe cycle.
          state_nxt  = PRESS;
          cnt_nxt    = cnt_inc;
          button_nxt = {cap_row, col};
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      PRESS: begin
        state_nxt = WAIT_RELEASE;
        cnt_nxt   = '0;
      end
      WAIT_RELEASE: begin
        if (row_hit) begin
          cnt_nxt = '0;
        end else if (cnt >= DEB_LAST) begin
          state_nxt = SCAN;
          col_nxt   = col + 2'd1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: state_nxt = SCAN;
    endcase
  end

  assign col_n          = ~(4'b0001 << col);
  assign button_pressed = (state == PRESS);
  assign key_held       = (state == PRESS) || (state == WAIT_RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a key-matrix model drives row_n from col_n, and each
// press scenario is scored by strobe count and encoded key against the pressed mask.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic       button_pressed;
  logic [3:0] button;
  logic       key_held;

  logic [15:0] keys;
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_strobes = 0;
  logic [3:0]  last_code = 4'h0;
  logic        prev_bp = 1'b0;

  keypad_scanner #(.SCAN_TICKS(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .row_n          (row_n),
    .col_n          (col_n),
    .button_pressed (button_pressed),
    .button         (button),
    .key_held       (key_held)
  );

  always #5 clk = ~clk;

  // Pressed key (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (button_pressed) begin
      n_strobes++;
      last_code = button;
      check("strobe_key_held", {31'd0, key_held}, 32'd1);
      check("strobe_single", {31'd0, prev_bp}, 32'd0);
    end
    prev_bp = button_pressed;
    check("col_onecold", $countones(~col_n), 32'd1);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_col"},  {28'd0, col_n}, 32'hE);
    check({tag, "_btn"},  {28'd0, button}, 32'h0);
    check({tag, "_bp"},   {31'd0, button_pressed}, 32'd0);
    check({tag, "_held"}, {31'd0, key_held}, 32'd0);
  endtask

  // Reference: keys share one column, so the lowest pressed row wins.
  function automatic logic [3:0] ref_code(input logic [15:0] mask);
    logic [3:0] code = 4'h0;
    for (int r = 3; r >= 0; r--)
      for (int c = 0; c < 4; c++)
        if (mask[r*4+c]) code = 4'(r*4 + c);
    return code;
  endfunction

  task automatic wait_col(input logic [3:0] want);
    int n = 0;
    while (col_n != want && n < 100) begin cycles(1); n++; end
    check("wait_col", {28'd0, col_n}, {28'd0, want});
  endtask

  task automatic press_release(input string tag, input logic [15:0] mask, input int bounce,
                               input int period, input int hold, input int idle);
    int s0 = n_strobes;
    for (int i = 0; i < bounce; i++) begin
      keys = ((i / period) % 2 == 0) ? mask : 16'h0;
      cycles(1);
    end
    keys = mask;
    cycles(hold);
    keys = 16'h0;
    cycles(idle);
    check({tag, "_count"}, n_strobes - s0, 32'd1);
    check({tag, "_code"}, {28'd0, last_code}, {28'd0, ref_code(mask)});
    check({tag, "_button"}, {28'd0, button}, {28'd0, ref_code(mask)});
    check({tag, "_released"}, {31'd0, key_held}, 32'd0);
  endtask

  initial begin
    int s0, n;
    logic [3:0] exp_col;
    logic [3:0] held_code;
    reset = 1'b1;
    keys  = 16'h0;
    cycles(2);
    check_reset_vals("reset");
    reset = 1'b0;

    for (int k = 1; k <= 40; k++) begin
      cycles(1);
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      check("idle_col", {28'd0, col_n}, {28'd0, exp_col});
    end
    check("idle_no_strobe", n_strobes, 32'd0);

    s0 = n_strobes;
    keys[9] = 1'b1;
    cycles(60);
    check("k9_count", n_strobes - s0, 32'd1);
    check("k9_code", {28'd0, last_code}, 32'd9);
    check("k9_held", {31'd0, key_held}, 32'd1);
    keys = 16'h0;
    n = 0;
    while (key_held && n < 100) begin cycles(1); n++; end
    check("k9_release_latency", n, 32'd10);
    check("k9_resume_col", {28'd0, col_n}, 32'hB);
    cycles(20);

    s0 = n_strobes;
    for (int i = 0; i < 30; i++) begin
      keys[3] = ((i / 3) % 2 == 0);
      cycles(1);
    end
    keys[3] = 1'b1;
    cycles(60);
    keys = 16'h0;
    cycles(30);
    check("bounce_count", n_strobes - s0, 32'd1);
    check("bounce_code", {28'd0, last_code}, 32'd3);

    s0 = n_strobes;
    wait_col(4'b1110);
    cycles(11);
    keys[3] = 1'b1;
    cycles(5);
    keys = 16'h0;
    cycles(30);
    check("glitch_count", n_strobes - s0, 32'd0);
    check("glitch_button_kept", {28'd0, button}, 32'd3);

    s0 = n_strobes;
    keys = (16'h1 << 4) | (16'h1 << 12);
    cycles(60);
    check("multi_count", n_strobes - s0, 32'd1);
    check("multi_code", {28'd0, last_code}, 32'd4);
    keys[10] = 1'b1;
    cycles(40);
    check("norollover_count", n_strobes - s0, 32'd1);
    keys = 16'h0;
    cycles(30);
    press_release("k10", 16'h1 << 10, 0, 1, 60, 30);

    // Reset while the press is still being debounced.
    s0 = n_strobes;
    wait_col(4'b1110);
    keys[15] = 1'b1;
    wait_col(4'b0111);
    cycles(5);
    reset = 1'b1;
    keys  = 16'h0;
    cycles(1);
    check_reset_vals("rst_deb");
    cycles(1);
    reset = 1'b0;
    cycles(30);
    check("rst_deb_no_strobe", n_strobes - s0, 32'd0);
    press_release("k15a", 16'h1 << 15, 0, 1, 60, 30);

    // Reset while waiting for release.
    s0 = n_strobes;
    keys[15] = 1'b1;
    n = 0;
    while (!button_pressed && n < 100) begin cycles(1); n++; end
    check("rst_wr_strobe_seen", {31'd0, button_pressed}, 32'd1);
    cycles(4);
    reset = 1'b1;
    keys  = 16'h0;
    cycles(1);
    check_reset_vals("rst_wr");
    cycles(1);
    reset = 1'b0;
    cycles(30);
    check("rst_wr_count", n_strobes - s0, 32'd1);
    check("rst_wr_button", {28'd0, button}, 32'h0);
    press_release("k15b", 16'h1 << 15, 0, 1, 60, 30);

    for (int it = 0; it < 12; it++) begin
      int c, bounce, period;
      logic [3:0] rmask;
      logic [15:0] mask;
      c      = $urandom_range(0, 3);
      rmask  = 4'($urandom_range(1, 15));
      mask   = 16'h0;
      for (int r = 0; r < 4; r++) if (rmask[r]) mask[r*4+c] = 1'b1;
      bounce = ($urandom_range(0, 1) == 1) ? $urandom_range(6, 24) : 0;
      period = $urandom_range(1, 4);
      press_release("rand", mask, bounce, period, $urandom_range(40, 70), $urandom_range(25, 40));
      if ($urandom_range(0, 1) == 1) begin
        s0 = n_strobes;
        held_code = button;
        keys[$urandom_range(0, 15)] = 1'b1;
        cycles($urandom_range(1, 6));
        keys = 16'h0;
        cycles(25);
        check("rand_glitch_count", n_strobes - s0, 32'd0);
        check("rand_glitch_button", {28'd0, button}, {28'd0, held_code});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
